// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes and the burst slave state encoding.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    BURST  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bram_sp_be.sv
// Block RAM with four byte-write enables and a registered read, kept in a shape
// synthesis tools infer as a RAM primitive.
module bram_sp_be #(
  parameter int ADR_W = 10
) (
  input  logic             clk,
  input  logic [ADR_W-1:0] rd_adr,
  input  logic             we,
  input  logic [ADR_W-1:0] wr_adr,
  input  logic [3:0]       be,
  input  logic [31:0]      wdat,
  output logic [31:0]      rdat
);

  logic [31:0] mem [0:(1<<ADR_W)-1];

  // Write goes to the beat's word while the read side already prefetches the next
  // word, so burst writes and mixed bursts keep one word per clock.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) begin
        mem[wr_adr][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
    rdat <= mem[rd_adr];
  end

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone block-RAM slave with classic and incrementing-burst support.
// Optional write protect input (wp_i) enabled by `define WB_BRAM_WRITE_PROTECT_EN.
//
// state  | meaning
// IDLE   | no transfer accepted; RAM addressed from wb_adr_i
// SINGLE | classic access accepted, ack for one beat then back to IDLE
// BURST  | incrementing burst, one beat per clock while stb is held
module wb_bram_burst
  import wb_pkg::*;
#(
  parameter int ADR_W = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_we_i,
`ifdef WB_BRAM_WRITE_PROTECT_EN
  input  logic        wp_i,
`endif
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  localparam logic [ADR_W-1:0] ONE = ADR_W'(1);

  bus_state_e       state, state_d;
  logic [ADR_W-1:0] cnt, cnt_d;
  logic             ack_r, ack_d;
  logic             rd_seen;
  logic             beat;
  logic             wr_ok;
  logic             wr_en;
  logic [ADR_W-1:0] adr_word;
  logic [ADR_W-1:0] rd_adr;
  logic [31:0]      rdat;
  logic             unused_adr;

  assign adr_word   = wb_adr_i[ADR_W+1:2];
  assign unused_adr = ^{wb_adr_i[31:ADR_W+2], wb_adr_i[1:0]};

  assign wb_ack_o = ack_r & wb_cyc_i & wb_stb_i;
  assign beat     = wb_ack_o;

`ifdef WB_BRAM_WRITE_PROTECT_EN
  assign wr_ok = ~wp_i;
`else
  assign wr_ok = 1'b1;
`endif

  assign wr_en = beat & wb_we_i & wr_ok;

  // Prefetch the next word on a completing beat; re-read the current one while stalled.
  always_comb begin
    rd_adr = cnt;
    if (state == IDLE) begin
      rd_adr = adr_word;
    end else if (beat) begin
      rd_adr = cnt + ONE;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ack_d   = ack_r;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          cnt_d   = adr_word;
          ack_d   = 1'b1;
          state_d = (wb_cti_i == CTI_INCR) ? BURST : SINGLE;
        end
      end
      SINGLE: begin
        if (!wb_cyc_i || beat) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      BURST: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end else if (beat) begin
          cnt_d = cnt + ONE;
          if (wb_cti_i != CTI_INCR) begin
            state_d = IDLE;
            ack_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_r   <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ack_r <= ack_d;
      if (beat && !wb_we_i) begin
        rd_seen <= 1'b1;
      end
    end
  end

  // The RAM output is undefined until something has been read, so hide it until then.
  assign wb_dat_o = (rd_seen | (ack_r & ~wb_we_i)) ? rdat : 32'h0;

  bram_sp_be #(
    .ADR_W (ADR_W)
  ) u_ram (
    .clk    (sys_clk),
    .rd_adr (rd_adr),
    .we     (wr_en),
    .wr_adr (cnt),
    .be     (wb_sel_i),
    .wdat   (wb_dat_i),
    .rdat   (rdat)
  );

endmodule

// File: tb/tb_wb_bram_burst.sv
// Self-checking bench for wb_bram_burst: classic vector table plus burst corner sequences.
module tb_wb_bram_burst;
  import wb_pkg::*;

  localparam int ADR_W = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
`ifdef WB_BRAM_WRITE_PROTECT_EN
  logic        wp_i;
`endif

  wb_bram_burst #(.ADR_W(ADR_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_cti_i (wb_cti_i),
    .wb_we_i  (wb_we_i),
`ifdef WB_BRAM_WRITE_PROTECT_EN
    .wp_i     (wp_i),
`endif
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_ack_o (wb_ack_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic cyc, input logic stb, input logic we, input logic [2:0] cti,
                      input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(posedge sys_clk);
    #1;
    wb_cyc_i = cyc;
    wb_stb_i = stb;
    wb_we_i  = we;
    wb_cti_i = cti;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    @(negedge sys_clk);
  endtask

  task automatic sample(input string name, input logic exp_ack);
    chk({name, " ack"}, {31'b0, wb_ack_o}, {31'b0, exp_ack});
    if (wb_ack_o && !wb_we_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s data: unexpected read beat, got %h, want none", name, wb_dat_o);
      end else begin
        chk({name, " data"}, wb_dat_o, exp_q.pop_front());
      end
    end
  endtask

  task automatic classic(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp);
    int lat;
    if (!we) exp_q.push_back(exp);
    step(1'b1, 1'b1, we, CTI_CLASSIC, adr, dat, sel);
    lat = 0;
    while (!wb_ack_o && lat < 4) begin
      step(1'b1, 1'b1, we, CTI_CLASSIC, adr, dat, sel);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd1);
    sample(name, 1'b1);
    // strobe still held: ack must fall for the cycle after the beat
    step(1'b1, 1'b1, we, CTI_CLASSIC, adr, dat, sel);
    chk({name, " ack falls"}, {31'b0, wb_ack_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'h0);
    chk({name, " ack gated"}, {31'b0, wb_ack_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 32'h00, 32'h0,        4'hF, 32'h0};
    vecs[6]  = '{1'b1, 32'h04, 32'h1,        4'hF, 32'h0};
    vecs[7]  = '{1'b1, 32'h08, 32'h2,        4'hF, 32'h0};
    vecs[8]  = '{1'b1, 32'h0C, 32'h3,        4'hF, 32'h0};
    vecs[9]  = '{1'b1, 32'h3C, 32'hA000000F, 4'hF, 32'h0};
    vecs[10] = '{1'b1, 32'h1C, 32'h77777777, 4'hF, 32'h0};
    vecs[11] = '{1'b1, 32'h14, 32'h0BAD0005, 4'hF, 32'h0};
    vecs[12] = '{1'b0, 32'h0C, 32'h0,        4'hF, 32'h3};
    vecs[13] = '{1'b0, 32'h3C, 32'h0,        4'hF, 32'hA000000F};
    vecs[14] = '{1'b1, 32'h18, 32'h0BAD0006, 4'hF, 32'h0};

    sys_rst  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_cti_i = CTI_CLASSIC;
    wb_adr_i = 32'h0;
    wb_dat_i = 32'h0;
    wb_sel_i = 4'hF;
`ifdef WB_BRAM_WRITE_PROTECT_EN
    wp_i = 1'b0;
`endif
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset ack", {31'b0, wb_ack_o}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst  = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge sys_clk);
    chk("reset ack after release", {31'b0, wb_ack_o}, 32'd0);
    chk("reset dat_o", wb_dat_o, 32'h0);

    for (int i = 0; i < 15; i++) begin
      classic($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp);
    end

    // 4-beat incrementing burst read from word 0
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h3);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h0, 32'h0, 4'hF);  sample("burst accept", 1'b0);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h0, 32'h0, 4'hF);  sample("burst beat0", 1'b1);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h4, 32'h0, 4'hF);  sample("burst beat1", 1'b1);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h8, 32'h0, 4'hF);  sample("burst beat2", 1'b1);
    step(1'b1, 1'b1, 1'b0, CTI_EOB,  32'hC, 32'h0, 4'hF);  sample("burst beat3", 1'b1);
    step(1'b1, 1'b1, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'hF); sample("burst after eob", 1'b0);
    step(1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'hF); sample("burst idle", 1'b0);
    step(1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'hF);

    // burst from word 15 with a two-cycle stall, wrapping to word 0
    exp_q.push_back(32'hA000000F);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h3C, 32'h0, 4'hF); sample("wrap accept", 1'b0);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h3C, 32'h0, 4'hF); sample("wrap beat15", 1'b1);
    step(1'b1, 1'b0, 1'b0, CTI_INCR, 32'h00, 32'h0, 4'hF); sample("wrap stall0", 1'b0);
    step(1'b1, 1'b0, 1'b0, CTI_INCR, 32'h00, 32'h0, 4'hF); sample("wrap stall1", 1'b0);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h00, 32'h0, 4'hF); sample("wrap beat0", 1'b1);
    step(1'b1, 1'b1, 1'b0, CTI_EOB,  32'h04, 32'h0, 4'hF); sample("wrap beat1", 1'b1);
    step(1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'hF); sample("wrap idle", 1'b0);
    step(1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'hF);

    // burst write at word 5, aborted by dropping cyc after two beats
    step(1'b1, 1'b1, 1'b1, CTI_INCR, 32'h14, 32'h55550005, 4'hF); sample("abort accept", 1'b0);
    step(1'b1, 1'b1, 1'b1, CTI_INCR, 32'h14, 32'h55550005, 4'hF); sample("abort beat5", 1'b1);
    step(1'b1, 1'b1, 1'b1, CTI_INCR, 32'h18, 32'h66660006, 4'hF); sample("abort beat6", 1'b1);
    step(1'b0, 1'b0, 1'b1, CTI_INCR, 32'h1C, 32'hBADBAD07, 4'hF); sample("abort drop", 1'b0);
    step(1'b0, 1'b0, 1'b0, CTI_CLASSIC, 32'h0, 32'h0, 4'hF);      sample("abort idle", 1'b0);
    classic("abort rd5", 1'b0, 32'h14, 32'h0, 4'hF, 32'h55550005);
    classic("abort rd6", 1'b0, 32'h18, 32'h0, 4'hF, 32'h66660006);
    classic("abort rd7", 1'b0, 32'h1C, 32'h0, 4'hF, 32'h77777777);

`ifdef WB_BRAM_WRITE_PROTECT_EN
    classic("wp preload", 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 32'h0);
    wp_i = 1'b1;
    classic("wp write", 1'b1, 32'h8, 32'h12345678, 4'hF, 32'h0);
    wp_i = 1'b0;
    classic("wp readback", 1'b0, 32'h8, 32'h0, 4'hF, 32'hCAFEF00D);
`endif

    // reset in the middle of a burst read
    exp_q.push_back(32'hDEADBEEF);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h10, 32'h0, 4'hF); sample("rst accept", 1'b0);
    step(1'b1, 1'b1, 1'b0, CTI_INCR, 32'h10, 32'h0, 4'hF); sample("rst beat", 1'b1);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    @(negedge sys_clk);
    chk("rst mid ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst mid dat_o", wb_dat_o, 32'h0);
    @(posedge sys_clk);
    #1;
    sys_rst  = 1'b1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge sys_clk);
    chk("rst released ack", {31'b0, wb_ack_o}, 32'd0);

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, want finished");
    $fatal(1);
  end

endmodule
